// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - alu_op encodings, mul/div FSM states and op-class helpers for alu_md.
package alu_md_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_NOR   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_LUI   = 5'd10,
        OP_SLL   = 5'd11,
        OP_SRL   = 5'd12,
        OP_SRA   = 5'd13,
        OP_SLLV  = 5'd14,
        OP_SRLV  = 5'd15,
        OP_SRAV  = 5'd16,
        OP_MFHI  = 5'd17,
        OP_MFLO  = 5'd18,
        OP_MTHI  = 5'd19,
        OP_MTLO  = 5'd20,
        OP_MULT  = 5'd21,
        OP_MULTU = 5'd22,
        OP_DIV   = 5'd23,
        OP_DIVU  = 5'd24
    } alu_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_md(input alu_op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic uses_hilo(input alu_op_e op);
        return op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/alu_md_muldiv_iter.sv
// rtl/alu_md_muldiv_iter.sv - iterative shift-add multiplier / restoring divider, one bit per clock.
module alu_md_muldiv_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state;
    md_state_e          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   pl;
    logic [WIDTH-1:0]   pl_nxt;
    logic [WIDTH:0]     ph;
    logic [WIDTH:0]     ph_nxt;
    logic [WIDTH:0]     add_t;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic               last;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start)         state_nxt = MD_RUN;
            MD_RUN:  if (flush || last) state_nxt = MD_IDLE;
            default:                    state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MD_RUN);
        wr   = (state == MD_RUN) && last && !flush;
    end

    // ph/pl hold {partial product high, multiplier} for mult and {remainder, dividend->quotient} for div
    always_comb begin
        add_t = pl[0] ? (ph + {1'b0, mcand}) : ph;
        r_sh  = {ph[WIDTH-1:0], pl[WIDTH-1]};
        diff  = r_sh - {1'b0, mcand};
        if (div_r) begin
            ph_nxt = diff[WIDTH] ? r_sh : diff;
            pl_nxt = {pl[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            ph_nxt = {1'b0, add_t[WIDTH:1]};
            pl_nxt = {add_t[0], pl[WIDTH-1:1]};
        end
    end

    assign prod = {ph_nxt[WIDTH-1:0], pl_nxt};

    // Signed ops run on magnitudes; the sign is restored on the final iteration's output
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (div_r) begin
            res_lo = dz ? '1 : (neg_q ? -pl_nxt : pl_nxt);
            res_hi = neg_r ? -ph_nxt[WIDTH-1:0] : ph_nxt[WIDTH-1:0];
        end else begin
            {res_hi, res_lo} = neg_q ? -prod : prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            mcand <= '0;
            ph    <= '0;
            pl    <= '0;
        end else if (state == MD_IDLE && start) begin
            cnt   <= '0;
            div_r <= is_div;
            neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed & a[WIDTH-1];
            dz    <= (b == '0);
            mcand <= (is_signed & b[WIDTH-1]) ? -b : b;
            ph    <= '0;
            pl    <= (is_signed & a[WIDTH-1]) ? -a : a;
        end else if (state == MD_RUN) begin
            cnt   <= cnt + 1'b1;
            ph    <= ph_nxt;
            pl    <= pl_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= wr;
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - EX-stage ALU: single-cycle integer ops, HI/LO registers, iterative mul/div and stall.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int OP_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic               flush,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   c,
    output logic               ovf,
    output logic               stall,
    output logic               md_busy,
    output logic               md_done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    alu_op_e            op;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   dif;
    logic [SHAMT_W-1:0] vsh;
    logic               md_start;
    logic               md_wr;
    logic               mt_en;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign op  = alu_op_e'(alu_op[4:0]);
    assign sum = a + b;
    assign dif = a - b;
    assign vsh = a[SHAMT_W-1:0];

    // Only HI/LO consumers wait on the engine; independent ops keep flowing
    assign stall    = ex_valid & md_busy & (is_md(op) | uses_hilo(op));
    assign md_start = ex_valid & is_md(op) & ~flush & ~md_busy;
    assign mt_en    = ex_valid & ~stall;

    always_comb begin
        c   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                c   = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c   = dif;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: c = sum;
            OP_SUBU: c = dif;
            OP_AND:  c = a & b;
            OP_OR:   c = a | b;
            OP_XOR:  c = a ^ b;
            OP_NOR:  c = ~(a | b);
            OP_SLT:  c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: c = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:  c = b << 16;
            OP_SLL:  c = b << shamt;
            OP_SRL:  c = b >> shamt;
            OP_SRA:  c = $unsigned($signed(b) >>> shamt);
            OP_SLLV: c = b << vsh;
            OP_SRLV: c = b >> vsh;
            OP_SRAV: c = $unsigned($signed(b) >>> vsh);
            OP_MFHI: c = hi;
            OP_MFLO: c = lo;
            default: c = '0;
        endcase
    end

    alu_md_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .flush     (flush),
        .is_div    (op inside {OP_DIV, OP_DIVU}),
        .is_signed (op inside {OP_MULT, OP_DIV}),
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_done),
        .wr        (md_wr),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (md_wr) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (mt_en && op == OP_MTHI) hi <= a;
            if (mt_en && op == OP_MTLO) lo <= a;
        end
    end

endmodule
